tx_slot_writer: RTL

//  Upstream producer for the TX frame slot ring consumed by the GMII sender. Accepts a frame

---
 rtl/tx_slot_writer_pkg.sv | 36 +++
 rtl/tx_slot_writer_if.sv | 26 ++
 rtl/tx_slot_writer_space.sv | 26 ++
 rtl/tx_slot_writer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tx_slot_writer_pkg.sv
// Shared constants, header layout and FSM encoding for the TX slot writer.
package ethpipe_tx_pkg;

    localparam int HDR_WORDS = 7;

    localparam logic [2:0] HW_LEN   = 3'd0;
    localparam logic [2:0] HW_TS0   = 3'd1;
    localparam logic [2:0] HW_TS1   = 3'd2;
    localparam logic [2:0] HW_TS2   = 3'd3;
    localparam logic [2:0] HW_TS3   = 3'd4;
    localparam logic [2:0] HW_HASH0 = 3'd5;
    localparam logic [2:0] HW_HASH1 = 3'd6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SPACE  = 3'd1,
        HDR    = 3'd2,
        DATA   = 3'd3,
        COMMIT = 3'd4,
        ABORT  = 3'd5,
        DRAIN  = 3'd6
    } state_t;

    // Number of 16b data words needed to carry len bytes.
    function automatic logic [15:0] data_words(input logic [15:0] len);
        logic [16:0] t;
        t = {1'b0, len} + 17'd1;
        return t[16:1];
    endfunction

    // Total slot words (header plus data) occupied by one frame.
    function automatic logic [15:0] slot_words(input logic [15:0] len);
        return data_words(len) + 16'(HDR_WORDS);
    endfunction

endpackage

// File: rtl/tx_slot_writer_if.sv
// Descriptor and data-word handshake between the frame producer and the slot writer.
interface tx_slot_writer_if;
    logic        desc_valid;
    logic        desc_ready;
    logic [15:0] desc_len;
    logic [63:0] desc_timestamp;
    logic [31:0] desc_hash;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;

    modport master (
        output desc_valid, desc_len, desc_timestamp, desc_hash,
        input  desc_ready,
        output in_valid, in_data, in_last,
        input  in_ready
    );

    modport slave (
        input  desc_valid, desc_len, desc_timestamp, desc_hash,
        output desc_ready,
        input  in_valid, in_data, in_last,
        output in_ready
    );
endinterface

// File: rtl/tx_slot_writer_space.sv
// Ring free-space tracker: registers rd-wr-1 and flags whether a frame of
// 'need' words fits. The one-cycle latency is hidden by the SPACE state.
module tx_slot_space
    import ethpipe_tx_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_ptr,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic [15:0]       need,
    output logic              fits
);

    logic [ADDR_W-1:0] free_q;

    // Free words in the ring; one slot is always kept empty so full != empty.
    always_ff @(posedge clk) begin
        if (rst) free_q <= '0;
        else     free_q <= rd_ptr - wr_ptr - 1'b1;
    end

    assign fits = (32'(free_q) >= 32'(need));

endmodule

// File: rtl/tx_slot_writer.sv
// TX slot writer: stores a 7-word header plus the frame data words into the
// slot ring and publishes mem_wr_ptr only after the whole frame is written.
// Optional statistics counters are enabled by defining TX_SLOT_WR_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for a descriptor
// SPACE  | waiting for enough free ring words for header + data
// HDR    | writing header words 0..6
// DATA   | writing data words from the input stream
// COMMIT | publishing the write cursor to mem_wr_ptr
// ABORT  | frame abandoned, nothing published
// DRAIN  | discarding input words up to in_last
module tx_slot_writer
    import ethpipe_tx_pkg::*;
#(
    parameter int          ADDR_W        = 14,
    parameter logic [15:0] MIN_FRAME_LEN = 16'd14,
    parameter logic [15:0] MAX_FRAME_LEN = 16'd1514
) (
    input  logic               gmii_tx_clk,
    input  logic               sys_rst,
    tx_slot_writer_if.slave    tx,
    output logic [ADDR_W-1:0]  slot_wr_addr,
    output logic [15:0]        slot_wr_data,
    output logic [1:0]         slot_wr_byte_en,
    output logic               slot_wr_en,
    input  logic [ADDR_W-1:0]  mem_rd_ptr,
    output logic [ADDR_W-1:0]  mem_wr_ptr
`ifdef TX_SLOT_WR_STATS_EN
    ,
    output logic [31:0]        frame_cnt,
    output logic [31:0]        drop_cnt
`endif
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cur;
    logic [2:0]        hdr_cnt;
    logic [15:0]       data_cnt;
    logic [15:0]       len_q;
    logic [63:0]       ts_q;
    logic [31:0]       hash_q;
    logic              abort_drain;
    logic [15:0]       hdr_word;
    logic [15:0]       need_words;
    logic [15:0]       nd_q;
    logic              fits;
    logic              desc_hs;
    logic              beat;
    logic              len_ok;
    logic              last_beat;

    assign slot_wr_byte_en = 2'b11;
    assign desc_hs   = tx.desc_valid & tx.desc_ready;
    assign beat      = tx.in_valid & tx.in_ready;
    assign len_ok    = (tx.desc_len >= MIN_FRAME_LEN) && (tx.desc_len <= MAX_FRAME_LEN);
    assign nd_q      = data_words(len_q);
    assign need_words = slot_words(len_q);
    assign last_beat = ((data_cnt + 16'd1) == nd_q);

    tx_slot_space #(.ADDR_W(ADDR_W)) u_space (
        .clk    (gmii_tx_clk),
        .rst    (sys_rst),
        .rd_ptr (mem_rd_ptr),
        .wr_ptr (mem_wr_ptr),
        .need   (need_words),
        .fits   (fits)
    );

    // State register.
    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_n;
    end

    // Next-state decision.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (desc_hs) state_n = len_ok ? SPACE : DRAIN;
            SPACE:  if (fits) state_n = HDR;
            HDR:    if (hdr_cnt == HW_HASH1) state_n = DATA;
            DATA: begin
                if (beat) begin
                    if (last_beat)        state_n = tx.in_last ? COMMIT : ABORT;
                    else if (tx.in_last)  state_n = ABORT;
                end
            end
            COMMIT: state_n = IDLE;
            ABORT:  state_n = abort_drain ? DRAIN : IDLE;
            DRAIN:  if (beat && tx.in_last) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Handshake outputs; held low while reset is asserted.
    always_comb begin
        tx.desc_ready = 1'b0;
        tx.in_ready   = 1'b0;
        case (state)
            IDLE:        tx.desc_ready = ~sys_rst;
            DATA, DRAIN: tx.in_ready   = ~sys_rst;
            default: ;
        endcase
    end

    // Header word selected by the header counter.
    always_comb begin
        hdr_word = len_q;
        case (hdr_cnt)
            HW_TS0:   hdr_word = ts_q[63:48];
            HW_TS1:   hdr_word = ts_q[47:32];
            HW_TS2:   hdr_word = ts_q[31:16];
            HW_TS3:   hdr_word = ts_q[15:0];
            HW_HASH0: hdr_word = hash_q[31:16];
            HW_HASH1: hdr_word = hash_q[15:0];
            default:  hdr_word = len_q;
        endcase
    end

    // Descriptor latch, write cursor, registered slot port and pointer publish.
    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            cur          <= '0;
            hdr_cnt      <= '0;
            data_cnt     <= '0;
            len_q        <= '0;
            ts_q         <= '0;
            hash_q       <= '0;
            abort_drain  <= 1'b0;
            slot_wr_en   <= 1'b0;
            slot_wr_addr <= '0;
            slot_wr_data <= '0;
            mem_wr_ptr   <= '0;
        end else begin
            slot_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (desc_hs) begin
                        len_q       <= tx.desc_len;
                        ts_q        <= tx.desc_timestamp;
                        hash_q      <= tx.desc_hash;
                        cur         <= mem_wr_ptr;
                        hdr_cnt     <= '0;
                        data_cnt    <= '0;
                        abort_drain <= 1'b0;
                    end
                end
                HDR: begin
                    slot_wr_en   <= 1'b1;
                    slot_wr_addr <= cur;
                    slot_wr_data <= hdr_word;
                    cur          <= cur + 1'b1;
                    hdr_cnt      <= hdr_cnt + 3'd1;
                end
                DATA: begin
                    if (beat) begin
                        slot_wr_en   <= 1'b1;
                        slot_wr_addr <= cur;
                        slot_wr_data <= tx.in_data;
                        cur          <= cur + 1'b1;
                        data_cnt     <= data_cnt + 16'd1;
                        // Stream is longer than the descriptor: discard the rest.
                        if (last_beat && !tx.in_last) abort_drain <= 1'b1;
                    end
                end
                COMMIT: mem_wr_ptr <= cur;
                default: ;
            endcase
        end
    end

`ifdef TX_SLOT_WR_STATS_EN
    logic drop_evt;
    assign drop_evt = (state == ABORT) || ((state == IDLE) && desc_hs && !len_ok);

    // Saturating committed-frame and dropped-frame counters.
    always_ff @(posedge gmii_tx_clk) begin
        if (sys_rst) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if ((state == COMMIT) && (frame_cnt != '1)) frame_cnt <= frame_cnt + 32'd1;
            if (drop_evt && (drop_cnt != '1))           drop_cnt  <= drop_cnt + 32'd1;
        end
    end
`endif

endmodule
